// File: rtl/mag_sched_pkg.sv
// Shared constants and types for the mag_sched magnitude scheduler.
package mag_sched_pkg;

    localparam int SAMPLE_W = 12;  // signed X/Y sample width
    localparam int MAG_W    = 13;  // engine magnitude width
    localparam int ID_W_MAX = 3;   // widest requester ID (N_REQ up to 8)

    // Requester ID width: log2(N_REQ), never narrower than one bit.
    function automatic int id_width(input int n_req);
        return (n_req <= 2) ? 1 : $clog2(n_req);
    endfunction

    // One result FIFO entry: source channel and its magnitude.
    typedef struct packed {
        logic [ID_W_MAX-1:0] id;
        logic [MAG_W-1:0]    mag;
    } res_entry_t;

endpackage

// File: rtl/mag_sched_rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request at or above Ptr,
// wrapping around. Purely combinational.
module rr_arbiter
    import mag_sched_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int IDW   = id_width(N_REQ)
) (
    input  logic [N_REQ-1:0] Req_Vec,
    input  logic [IDW-1:0]   Ptr,
    output logic [N_REQ-1:0] Grant,
    output logic [IDW-1:0]   Grant_Idx,
    output logic             Any_Req
);

    logic [IDW-1:0] idx;

    // Scan from the farthest slot back towards Ptr so the nearest request wins.
    always_comb begin
        Grant     = '0;
        Grant_Idx = '0;
        Any_Req   = 1'b0;
        idx       = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = Ptr + IDW'(k);
            if (Req_Vec[idx]) begin
                Grant_Idx = idx;
                Any_Req   = 1'b1;
            end
        end
        if (Any_Req) begin
            Grant[Grant_Idx] = 1'b1;
        end
    end

endmodule

// File: rtl/mag_sched.sv
// mag_sched: round-robin scheduler sharing one fixed-latency magnitude engine
// among N_REQ requesters, with credit-controlled issue and a tagged result FIFO.
// Optional macro MAG_SCHED_STATS_EN adds Issue_Count / Stall_Count outputs.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Req_Ready is one-hot (or zero) and depends combinationally on
// Req_Valid; Out_Valid never depends on Out_Ready, and the head entry stays
// stable while Out_Valid is high and Out_Ready is low.
module mag_sched
    import mag_sched_pkg::*;
#(
    parameter  int N_REQ      = 4,
    parameter  int ENG_LAT    = 1,
    parameter  int FIFO_DEPTH = 4,
    localparam int IDW        = id_width(N_REQ)
) (
    input  logic                          Clk,
    input  logic                          Reset_n,
    input  logic [N_REQ-1:0]              Req_Valid,
    input  logic [N_REQ*SAMPLE_W-1:0]     Req_X,
    input  logic [N_REQ*SAMPLE_W-1:0]     Req_Y,
    output logic [N_REQ-1:0]              Req_Ready,
    output logic signed [SAMPLE_W-1:0]    Eng_X,
    output logic signed [SAMPLE_W-1:0]    Eng_Y,
    input  logic [MAG_W-1:0]              Eng_Magnitude,
    output logic                          Out_Valid,
    input  logic                          Out_Ready,
    output logic [IDW-1:0]                Out_Id,
`ifdef MAG_SCHED_STATS_EN
    output logic [MAG_W-1:0]              Out_Magnitude,
    output logic [15:0]                   Issue_Count,
    output logic [15:0]                   Stall_Count
`else
    output logic [MAG_W-1:0]              Out_Magnitude
`endif
);

    localparam int PIPE_D = ENG_LAT + 1;              // tag stages, last one aligned with Eng_Magnitude
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    logic [IDW-1:0]             ptr;
    logic [N_REQ-1:0]           grant;
    logic [IDW-1:0]             grant_idx;
    logic                       any_req;
    logic                       can_issue;
    logic                       accept;
    logic [PIPE_D-1:0]          tag_valid;
    logic [PIPE_D-1:0][IDW-1:0] tag_id;
    logic [CNT_W-1:0]           inflight;
    logic [CNT_W-1:0]           fifo_count;
    logic [AW-1:0]              wr_ptr;
    logic [AW-1:0]              rd_ptr;
    res_entry_t                 fifo_mem [FIFO_DEPTH];
    res_entry_t                 push_entry;
    res_entry_t                 head;
    logic                       push;
    logic                       pop;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .Req_Vec   (Req_Valid),
        .Ptr       (ptr),
        .Grant     (grant),
        .Grant_Idx (grant_idx),
        .Any_Req   (any_req)
    );

    // Credits: everything accepted but not yet popped must fit in the FIFO.
    always_comb begin
        inflight = '0;
        for (int k = 0; k < PIPE_D; k++) begin
            inflight = inflight + CNT_W'(tag_valid[k]);
        end
        can_issue = ({1'b0, fifo_count} + {1'b0, inflight}) < (CNT_W + 1)'(FIFO_DEPTH);
        Req_Ready = (Reset_n && can_issue) ? grant : '0;
        accept    = |Req_Ready;
    end

    // Issue stage: capture the winner's operands and advance the pointer past it.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            ptr   <= '0;
            Eng_X <= '0;
            Eng_Y <= '0;
        end else if (accept) begin
            ptr   <= grant_idx + IDW'(1);
            Eng_X <= Req_X[int'(grant_idx) * SAMPLE_W +: SAMPLE_W];
            Eng_Y <= Req_Y[int'(grant_idx) * SAMPLE_W +: SAMPLE_W];
        end
    end

    // Tag pipe: follows each issued operand pair through the engine latency.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            tag_valid <= '0;
            tag_id    <= '0;
        end else begin
            tag_valid <= {tag_valid[PIPE_D-2:0], accept};
            tag_id    <= {tag_id[PIPE_D-2:0], grant_idx};
        end
    end

    // FIFO control and head view; outputs read zero while empty.
    always_comb begin
        push           = tag_valid[PIPE_D-1];
        pop            = Out_Valid && Out_Ready;
        push_entry.id  = ID_W_MAX'(tag_id[PIPE_D-1]);
        push_entry.mag = Eng_Magnitude;
        head           = fifo_mem[rd_ptr];
        Out_Valid      = (fifo_count != '0);
        Out_Id         = Out_Valid ? head.id[IDW-1:0] : '0;
        Out_Magnitude  = Out_Valid ? head.mag : '0;
    end

    // FIFO storage: payload needs no reset, the pointers define validity.
    always_ff @(posedge Clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= push_entry;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Credits guarantee a free slot for every tag that reaches the FIFO.
    a_no_overflow: assert property (@(posedge Clk) disable iff (!Reset_n)
        !(push && fifo_count == CNT_W'(FIFO_DEPTH)));

`ifdef MAG_SCHED_STATS_EN
    // Activity counters, wrapping at 16 bits.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            Issue_Count <= '0;
            Stall_Count <= '0;
        end else begin
            if (accept) Issue_Count <= Issue_Count + 16'd1;
            if (|Req_Valid && !can_issue) Stall_Count <= Stall_Count + 16'd1;
        end
    end
`endif

endmodule
